// File: rtl/ula_stack_seq.sv
// rtl/ula_stack_seq.sv - operand sequencer and LIFO data stack feeding the combinational ULA
// Optional macro ULA_STACK_DIVZERO_TRAP_EN: trap DIV by zero at LOAD instead of writing all-ones.
module ula_stack_seq #(
  parameter  int DATA_SIZE = 11,
  parameter  int DEPTH     = 8,
  localparam int DW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_op,
  input  logic [DATA_SIZE-1:0] cmd_data,
  output logic [DATA_SIZE-1:0] ula_operand_a,
  output logic [DATA_SIZE-1:0] ula_operand_b,
  output logic [3:0]           ula_opcode,
  input  logic [DATA_SIZE-1:0] ula_out,
  output logic [DATA_SIZE-1:0] top_data,
  output logic [DW-1:0]        depth,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_POP  = 4'd2;
  localparam logic [3:0] OP_DUP  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd13;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} state_t;

  state_t               state, state_nxt;
  logic [DATA_SIZE-1:0] stack [DEPTH];
  logic [DW-1:0]        cnt, dm1, dm2;
  logic [AW-1:0]        ia0, ia1, ia2;
  logic [3:0]           op_q;
  logic [DATA_SIZE-1:0] result;
  logic                 accept, is_alu;
  logic [1:0]           chk;
`ifdef ULA_STACK_DIVZERO_TRAP_EN
  logic                 div_zero;
`endif

  assign dm1 = cnt - 1'b1;
  assign dm2 = cnt - 2'd2;
  assign ia0 = cnt[AW-1:0];
  assign ia1 = dm1[AW-1:0];
  assign ia2 = dm2[AW-1:0];

  assign cmd_ready = (state == IDLE) && rst_n;
  assign busy      = (state != IDLE);
  assign depth     = cnt;
  assign top_data  = (cnt == '0) ? '0 : stack[ia1];
  assign accept    = cmd_valid && cmd_ready;
  assign is_alu    = (cmd_op >= 4'd4) && (cmd_op <= 4'd13);
`ifdef ULA_STACK_DIVZERO_TRAP_EN
  assign div_zero  = (op_q == OP_DIV) && (stack[ia1] == '0);
`endif

  // Admission check of the offered command against the current depth
  always_comb begin
    chk = 2'd0;
    case (cmd_op)
      OP_NOP:         chk = 2'd0;
      OP_PUSH:        if (cnt == FULL) chk = 2'd2;
      OP_POP:         if (cnt == '0) chk = 2'd1;
      OP_DUP:         if (cnt == '0) chk = 2'd1; else if (cnt == FULL) chk = 2'd2;
      OP_NOT:         if (cnt == '0) chk = 2'd1;
      4'd14, 4'd15:   chk = 2'd3;
      default:        if (cnt < DW'(2)) chk = 2'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && chk == 2'd0 && is_alu) state_nxt = LOAD;
`ifdef ULA_STACK_DIVZERO_TRAP_EN
      LOAD: state_nxt = div_zero ? IDLE : EXEC;
`else
      LOAD: state_nxt = EXEC;
`endif
      EXEC: state_nxt = WB;
      WB:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
      cnt           <= '0;
      op_q          <= '0;
      result        <= '0;
      ula_operand_a <= '0;
      ula_operand_b <= '0;
      ula_opcode    <= '0;
      err           <= 1'b0;
      err_code      <= 2'd0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          err_code <= chk;
          if (chk != 2'd0) begin
            err <= 1'b1;
          end else begin
            case (cmd_op)
              OP_PUSH: begin stack[ia0] <= cmd_data; cnt <= cnt + 1'b1; end
              OP_POP:  cnt <= dm1;
              OP_DUP:  begin stack[ia0] <= top_data; cnt <= cnt + 1'b1; end
              default: if (is_alu) op_q <= cmd_op;
            endcase
          end
        end
        LOAD: begin
`ifdef ULA_STACK_DIVZERO_TRAP_EN
          if (div_zero) begin
            err      <= 1'b1;
            err_code <= 2'd3;
          end else
`endif
          begin
            ula_operand_a <= (op_q == OP_NOT) ? '0 : stack[ia2];
            ula_operand_b <= stack[ia1];
            ula_opcode    <= op_q;
          end
        end
`ifdef ULA_STACK_DIVZERO_TRAP_EN
        EXEC: result <= ula_out;
`else
        // ULA output is undefined on divide by zero; keep X out of the stack
        EXEC: result <= (ula_opcode == OP_DIV && ula_operand_b == '0) ? {DATA_SIZE{1'b1}} : ula_out;
`endif
        WB: begin
          if (op_q == OP_NOT) begin
            stack[ia1] <= result;
          end else begin
            stack[ia2] <= result;
            cnt        <= dm1;
          end
          ula_operand_a <= '0;
          ula_operand_b <= '0;
          ula_opcode    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_stack_seq.sv
// tb/tb_ula_stack_seq.sv - self-checking bench for ula_stack_seq with a behavioural ULA and queue-based stack model
module tb_ula_stack_seq;
  localparam int DS = 11;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = 4'd0;
  logic [DS-1:0] cmd_data = '0;
  logic [DS-1:0] ula_operand_a, ula_operand_b, ula_out, top_data;
  logic [3:0]    ula_opcode;
  logic [3:0]    depth;
  logic          busy, err;
  logic [1:0]    err_code;

  int total = 0;
  int bad = 0;
  logic [DS-1:0] mq[$];

  always #5 clk = ~clk;

  ula_stack_seq #(.DATA_SIZE(DS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .ula_operand_a(ula_operand_a),
    .ula_operand_b(ula_operand_b), .ula_opcode(ula_opcode), .ula_out(ula_out),
    .top_data(top_data), .depth(depth), .busy(busy), .err(err), .err_code(err_code)
  );

  // Combinational ULA; divide by zero yields an arbitrary value the sequencer must not store
  function automatic logic [DS-1:0] ula_f(input logic [3:0] op, input logic [DS-1:0] a, input logic [DS-1:0] b);
    case (op)
      4'd4:  return a + b;
      4'd5:  return a - b;
      4'd6:  return a * b;
      4'd7:  return (b == '0) ? 11'h2AA : a / b;
      4'd8:  return a & b;
      4'd9:  return ~(a & b);
      4'd10: return a | b;
      4'd11: return a ^ b;
      4'd12: return (a < b) ? '1 : ((a == b) ? 11'd0 : 11'd1);
      4'd13: return ~b;
      default: return '0;
    endcase
  endfunction

  assign ula_out = ula_f(ula_opcode, ula_operand_a, ula_operand_b);

  task automatic model_step(input logic [3:0] op, input logic [DS-1:0] d, output logic [1:0] code, output int low);
    logic [DS-1:0] a, b;
    int n;
    n = mq.size();
    code = 2'd0;
    low = 0;
    if (op >= 4'd14) code = 2'd3;
    else if (op == 4'd1) begin if (n == DEPTH) code = 2'd2; else mq.push_back(d); end
    else if (op == 4'd2) begin if (n == 0) code = 2'd1; else void'(mq.pop_back()); end
    else if (op == 4'd3) begin
      if (n == 0) code = 2'd1;
      else if (n == DEPTH) code = 2'd2;
      else mq.push_back(mq[n-1]);
    end
    else if (op == 4'd13) begin
      if (n == 0) code = 2'd1;
      else begin low = 3; mq[n-1] = ~mq[n-1]; end
    end
    else if (op >= 4'd4) begin
      if (n < 2) code = 2'd1;
      else begin
        b = mq[n-1];
        a = mq[n-2];
        if (op == 4'd7 && b == '0) begin
`ifdef ULA_STACK_DIVZERO_TRAP_EN
          code = 2'd3;
          low = 1;
`else
          low = 3;
          void'(mq.pop_back());
          mq[n-2] = '1;
`endif
        end else begin
          low = 3;
          void'(mq.pop_back());
          mq[n-2] = ula_f(op, a, b);
        end
      end
    end
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mq.delete();
  endtask

  // Drives one command from IDLE and reports ready-low cycles, err-high cycles and EXEC-time ULA inputs
  task automatic issue(input logic [3:0] op, input logic [DS-1:0] d, output int low, output int errs,
                       output logic [DS-1:0] xa, output logic [DS-1:0] xb, output logic [3:0] xop);
    low = 0; errs = 0; xa = '0; xb = '0; xop = '0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 4'($urandom);
    cmd_data = DS'($urandom);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (err) errs++;
      if (i == 1) begin xa = ula_operand_a; xb = ula_operand_b; xop = ula_opcode; end
      if (cmd_ready) break;
      low++;
    end
    @(negedge clk);
    if (err) errs++;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", cmd_ready); end
    total++; if (depth !== 4'd0) begin bad++; $display("FAIL reset_depth got=%0d exp=0", depth); end
    total++; if (top_data !== 11'd0) begin bad++; $display("FAIL reset_top got=%0h exp=0", top_data); end
    total++; if ({err, err_code, busy} !== 4'd0) begin bad++; $display("FAIL reset_flags got=%0h exp=0", {err, err_code, busy}); end
    total++; if ({ula_operand_a, ula_operand_b, ula_opcode} !== 26'd0) begin bad++; $display("FAIL reset_ula got=%0h exp=0", {ula_operand_a, ula_operand_b, ula_opcode}); end
  endtask

  task automatic test_add();
    int low, errs; logic [DS-1:0] xa, xb; logic [3:0] xop;
    do_reset();
    issue(4'd1, 11'd5, low, errs, xa, xb, xop);
    issue(4'd1, 11'd3, low, errs, xa, xb, xop);
    issue(4'd4, 11'd0, low, errs, xa, xb, xop);
    total++; if (top_data !== 11'd8) begin bad++; $display("FAIL add_top got=%0h exp=8", top_data); end
    total++; if (depth !== 4'd1) begin bad++; $display("FAIL add_depth got=%0d exp=1", depth); end
    total++; if (low !== 3) begin bad++; $display("FAIL add_ready_low got=%0d exp=3", low); end
    total++; if ({xa, xb, xop} !== {11'd5, 11'd3, 4'd4}) begin bad++; $display("FAIL add_ula_ops got=%0h/%0h/%0h exp=5/3/4", xa, xb, xop); end
    total++; if (errs !== 0) begin bad++; $display("FAIL add_err got=%0d exp=0", errs); end
  endtask

  task automatic test_sub_cmp();
    int low, errs; logic [DS-1:0] xa, xb; logic [3:0] xop;
    logic [DS-1:0] vals [3][2];
    logic [3:0] ops [3];
    logic [DS-1:0] exp_v [3];
    vals[0][0] = 11'd3; vals[0][1] = 11'd5; ops[0] = 4'd5;  exp_v[0] = 11'h7FE;
    vals[1][0] = 11'd3; vals[1][1] = 11'd5; ops[1] = 4'd12; exp_v[1] = 11'h7FF;
    vals[2][0] = 11'd5; vals[2][1] = 11'd3; ops[2] = 4'd12; exp_v[2] = 11'h001;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      issue(4'd1, vals[k][0], low, errs, xa, xb, xop);
      issue(4'd1, vals[k][1], low, errs, xa, xb, xop);
      issue(ops[k], 11'd0, low, errs, xa, xb, xop);
      total++; if (top_data !== exp_v[k]) begin bad++; $display("FAIL subcmp_%0d_top got=%0h exp=%0h", k, top_data, exp_v[k]); end
    end
  endtask

  task automatic test_errors();
    int low, errs; logic [DS-1:0] xa, xb; logic [3:0] xop;
    do_reset();
    issue(4'd1, 11'd7, low, errs, xa, xb, xop);
    issue(4'd4, 11'd0, low, errs, xa, xb, xop);
    total++; if (errs !== 1) begin bad++; $display("FAIL uflow_err_cycles got=%0d exp=1", errs); end
    total++; if (err_code !== 2'd1) begin bad++; $display("FAIL uflow_code got=%0d exp=1", err_code); end
    total++; if ({depth, top_data} !== {4'd1, 11'd7}) begin bad++; $display("FAIL uflow_stack got=%0d/%0h exp=1/7", depth, top_data); end
    total++; if (low !== 0) begin bad++; $display("FAIL uflow_ready_low got=%0d exp=0", low); end
    issue(4'd15, 11'd0, low, errs, xa, xb, xop);
    total++; if ({errs[1:0], err_code} !== {2'd1, 2'd3}) begin bad++; $display("FAIL illegal got=%0d/%0d exp=1/3", errs, err_code); end
    issue(4'd0, 11'd0, low, errs, xa, xb, xop);
    total++; if (err_code !== 2'd0) begin bad++; $display("FAIL code_clear got=%0d exp=0", err_code); end
    do_reset();
    for (int k = 0; k < 9; k++) issue(4'd1, 11'(k), low, errs, xa, xb, xop);
    total++; if ({errs[1:0], err_code} !== {2'd1, 2'd2}) begin bad++; $display("FAIL oflow got=%0d/%0d exp=1/2", errs, err_code); end
    total++; if ({depth, top_data} !== {4'd8, 11'd7}) begin bad++; $display("FAIL oflow_stack got=%0d/%0h exp=8/7", depth, top_data); end
    issue(4'd2, 11'd0, low, errs, xa, xb, xop);
    total++; if (top_data !== 11'd6) begin bad++; $display("FAIL oflow_pop got=%0h exp=6", top_data); end
  endtask

  task automatic test_divzero();
    int low, errs; logic [DS-1:0] xa, xb; logic [3:0] xop;
    do_reset();
    issue(4'd1, 11'd9, low, errs, xa, xb, xop);
    issue(4'd1, 11'd0, low, errs, xa, xb, xop);
    issue(4'd7, 11'd0, low, errs, xa, xb, xop);
`ifdef ULA_STACK_DIVZERO_TRAP_EN
    total++; if ({errs[1:0], err_code} !== {2'd1, 2'd3}) begin bad++; $display("FAIL div0_err got=%0d/%0d exp=1/3", errs, err_code); end
    total++; if ({depth, top_data} !== {4'd2, 11'd0}) begin bad++; $display("FAIL div0_stack got=%0d/%0h exp=2/0", depth, top_data); end
    total++; if (low !== 1) begin bad++; $display("FAIL div0_ready_low got=%0d exp=1", low); end
`else
    total++; if ({errs[1:0], err_code} !== 4'd0) begin bad++; $display("FAIL div0_err got=%0d/%0d exp=0/0", errs, err_code); end
    total++; if ({depth, top_data} !== {4'd1, 11'h7FF}) begin bad++; $display("FAIL div0_stack got=%0d/%0h exp=1/7ff", depth, top_data); end
    total++; if (low !== 3) begin bad++; $display("FAIL div0_ready_low got=%0d exp=3", low); end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 4'd1;
    for (int k = 0; k < 3; k++) begin
      cmd_data = 11'(20 + k);
      @(posedge clk);
      #1;
    end
    cmd_op = 4'd3;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    total++; if ({depth, top_data} !== {4'd4, 11'd22}) begin bad++; $display("FAIL b2b_push got=%0d/%0h exp=4/16", depth, top_data); end
    cmd_valid = 1'b1;
    cmd_op = 4'd2;
    repeat (2) begin @(posedge clk); #1; end
    cmd_valid = 1'b0;
    @(negedge clk);
    total++; if ({depth, top_data} !== {4'd2, 11'd21}) begin bad++; $display("FAIL b2b_pop got=%0d/%0h exp=2/15", depth, top_data); end
  endtask

  task automatic test_reset_mid();
    int low, errs; logic [DS-1:0] xa, xb; logic [3:0] xop;
    do_reset();
    issue(4'd1, 11'd4, low, errs, xa, xb, xop);
    issue(4'd1, 11'd2, low, errs, xa, xb, xop);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 4'd6;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({ula_operand_a, ula_operand_b, ula_opcode} !== {11'd4, 11'd2, 4'd6}) begin bad++; $display("FAIL mid_exec_ula got=%0h exp=4/2/6", {ula_operand_a, ula_operand_b, ula_opcode}); end
    rst_n = 1'b0;
    #1;
    total++; if ({ula_operand_a, ula_operand_b, ula_opcode, top_data, depth, busy, err, err_code, cmd_ready} !== '0) begin bad++; $display("FAIL mid_reset_outputs got=%0h exp=0", {ula_operand_a, ula_operand_b, ula_opcode, top_data, depth, busy, err, err_code, cmd_ready}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mq.delete();
    total++; if ({cmd_ready, depth} !== {1'b1, 4'd0}) begin bad++; $display("FAIL mid_release got=%0b/%0d exp=1/0", cmd_ready, depth); end
  endtask

  task automatic test_random();
    int low, errs, elow; logic [DS-1:0] xa, xb, ea, eb, etop; logic [3:0] xop, op; logic [1:0] ecode;
    logic [DS-1:0] d;
    int n;
    do_reset();
    for (int t = 0; t < 300; t++) begin
      op = ($urandom_range(0, 99) < 30) ? 4'd1 : 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 3) == 0) ? 11'd0 : DS'($urandom);
      n = mq.size();
      eb = (n > 0) ? mq[n-1] : '0;
      ea = (op == 4'd13 || n < 2) ? '0 : mq[n-2];
      model_step(op, d, ecode, elow);
      etop = (mq.size() > 0) ? mq[mq.size()-1] : '0;
      issue(op, d, low, errs, xa, xb, xop);
      total++; if (low !== elow) begin bad++; $display("FAIL rnd%0d_ready_low op=%0d got=%0d exp=%0d", t, op, low, elow); end
      total++; if (errs !== ((ecode != 2'd0) ? 1 : 0)) begin bad++; $display("FAIL rnd%0d_err op=%0d got=%0d exp=%0d", t, op, errs, ecode != 2'd0); end
      total++; if (err_code !== ecode) begin bad++; $display("FAIL rnd%0d_code op=%0d got=%0d exp=%0d", t, op, err_code, ecode); end
      total++; if (depth !== 4'(mq.size())) begin bad++; $display("FAIL rnd%0d_depth op=%0d got=%0d exp=%0d", t, op, depth, mq.size()); end
      total++; if (top_data !== etop) begin bad++; $display("FAIL rnd%0d_top op=%0d got=%0h exp=%0h", t, op, top_data, etop); end
      if (elow == 3) begin
        total++; if ({xa, xb, xop} !== {ea, eb, op}) begin bad++; $display("FAIL rnd%0d_ula_ops got=%0h/%0h/%0h exp=%0h/%0h/%0h", t, xa, xb, xop, ea, eb, op); end
      end
      total++; if ({ula_operand_a, ula_operand_b, ula_opcode, busy} !== '0) begin bad++; $display("FAIL rnd%0d_idle_ula got=%0h exp=0", t, {ula_operand_a, ula_operand_b, ula_opcode, busy}); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_cmp();
    test_errors();
    test_divzero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
